// File: rtl/dda_column_store.sv
// Double-buffered per-column store for the DDA result stream. The DDA fills one bank while
// the renderer reads the other; banks swap on frame_sync_in after a complete frame.
// Optional: define DDA_COLUMN_STORE_VALID_EN for per-bank column-written bitmaps.
module dda_column_store #(
    parameter int SCREEN_WIDTH  = 320,
    parameter int SCREEN_HEIGHT = 180
) (
    input  logic        pixel_clk_in,
    input  logic        rst_in,
    input  logic        dda_fsm_out_tvalid,
    input  logic [37:0] dda_fsm_out_tdata,
    input  logic        dda_fsm_out_tlast,
    output logic        dda_fsm_out_tready,
    input  logic        frame_sync_in,
    input  logic [8:0]  rd_hcount_in,
    input  logic        rd_req_in,
    output logic [28:0] rd_data_out,
    output logic        rd_valid_out,
    output logic        frame_swapped_out,
    output logic        frame_dropped_out,
    output logic        beat_error_out,
    output logic [8:0]  cols_written_out
);
    localparam logic [8:0] WIDTH9  = 9'(SCREEN_WIDTH);
    localparam logic [7:0] HEIGHT8 = 8'(SCREEN_HEIGHT);

    typedef enum logic {FILL, DONE} state_t;

    state_t      state_q, state_d;
    logic        wbank_q, wbank_d;
    logic        tready_q, tready_d;
    logic        rd_valid_q, rd_valid_d;
    logic [28:0] rd_data_q, rd_data_d;
    logic        swapped_q, swapped_d;
    logic        dropped_q, dropped_d;
    logic        err_q, err_d;
    logic [8:0]  cols_q, cols_d;

    logic [28:0] mem0 [SCREEN_WIDTH];
    logic [28:0] mem1 [SCREEN_WIDTH];

    logic        accept, in_range, wr_en, swap, rd_ok, rd_vbit;
    logic [8:0]  wr_hc, cols_inc;
    logic [7:0]  lh_clamped;
    logic [28:0] wr_word, rd_word;

    always_comb begin
        accept     = dda_fsm_out_tvalid && tready_q;
        wr_hc      = dda_fsm_out_tdata[37:29];
        in_range   = wr_hc < WIDTH9;
        lh_clamped = (dda_fsm_out_tdata[28:21] > HEIGHT8) ? HEIGHT8 : dda_fsm_out_tdata[28:21];
        wr_word    = {lh_clamped, dda_fsm_out_tdata[20:0]};
        wr_en      = accept && in_range;
        cols_inc   = (in_range && cols_q != WIDTH9) ? cols_q + 9'd1 : cols_q;
        swap       = (state_q == DONE) && frame_sync_in;
        rd_ok      = rd_hcount_in < WIDTH9;
        // Read bank is always the one the DDA is not writing.
        rd_word    = wbank_q ? mem0[rd_hcount_in] : mem1[rd_hcount_in];
    end

`ifdef DDA_COLUMN_STORE_VALID_EN
    logic [SCREEN_WIDTH-1:0] vmap0_q, vmap0_d, vmap1_q, vmap1_d;

    always_comb begin
        vmap0_d = vmap0_q;
        vmap1_d = vmap1_q;
        if (wr_en) begin
            if (wbank_q) vmap1_d[wr_hc] = 1'b1;
            else         vmap0_d[wr_hc] = 1'b1;
        end
        // The bank about to become the write bank starts with no columns written.
        if (swap) begin
            if (wbank_q) vmap0_d = '0;
            else         vmap1_d = '0;
        end
        rd_vbit = rd_ok && (wbank_q ? vmap0_q[rd_hcount_in] : vmap1_q[rd_hcount_in]);
    end

    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
            vmap0_q <= '0;
            vmap1_q <= '0;
        end else begin
            vmap0_q <= vmap0_d;
            vmap1_q <= vmap1_d;
        end
    end
`else
    always_comb rd_vbit = 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        wbank_d    = wbank_q;
        swapped_d  = 1'b0;
        dropped_d  = 1'b0;
        err_d      = err_q;
        cols_d     = cols_q;
        rd_valid_d = rd_req_in;
        rd_data_d  = rd_data_q;
        case (state_q)
            FILL: begin
                if (accept) begin
                    cols_d = cols_inc;
                    if (!in_range) err_d = 1'b1;
                    if (dda_fsm_out_tlast) begin
                        state_d = DONE;
                        if (cols_inc != WIDTH9) err_d = 1'b1;
                    end
                end
                if (frame_sync_in) dropped_d = 1'b1;
            end
            DONE: begin
                if (frame_sync_in) begin
                    state_d   = FILL;
                    wbank_d   = !wbank_q;
                    cols_d    = '0;
                    swapped_d = 1'b1;
                end
            end
            default: state_d = FILL;
        endcase
        tready_d = (state_d == FILL);
        if (rd_req_in) rd_data_d = (rd_ok && rd_vbit) ? rd_word : '0;
    end

    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= FILL;
            wbank_q    <= 1'b0;
            tready_q   <= 1'b1;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            swapped_q  <= 1'b0;
            dropped_q  <= 1'b0;
            err_q      <= 1'b0;
            cols_q     <= '0;
        end else begin
            state_q    <= state_d;
            wbank_q    <= wbank_d;
            tready_q   <= tready_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            swapped_q  <= swapped_d;
            dropped_q  <= dropped_d;
            err_q      <= err_d;
            cols_q     <= cols_d;
        end
    end

    always_ff @(posedge pixel_clk_in) begin
        if (wr_en) begin
            if (wbank_q) mem1[wr_hc] <= wr_word;
            else         mem0[wr_hc] <= wr_word;
        end
    end

    assign dda_fsm_out_tready = tready_q;
    assign rd_data_out        = rd_data_q;
    assign rd_valid_out       = rd_valid_q;
    assign frame_swapped_out  = swapped_q;
    assign frame_dropped_out  = dropped_q;
    assign beat_error_out     = err_q;
    assign cols_written_out   = cols_q;
endmodule

// File: tb/tb_dda_column_store.sv
// Directed bench for dda_column_store: full frames, backpressure, dropped frame, errors,
// clamp/read edge cases and mid-frame reset.
module tb_dda_column_store;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tvalid = 1'b0;
    logic [37:0] tdata = '0;
    logic        tlast = 1'b0;
    logic        tready;
    logic        sync = 1'b0;
    logic [8:0]  rd_hc = '0;
    logic        rd_req = 1'b0;
    logic [28:0] rd_data;
    logic        rd_valid;
    logic        swapped, dropped, err;
    logic [8:0]  cols;

    int n_chk  = 0;
    int n_pass = 0;

    dda_column_store dut (
        .pixel_clk_in(clk), .rst_in(rst),
        .dda_fsm_out_tvalid(tvalid), .dda_fsm_out_tdata(tdata),
        .dda_fsm_out_tlast(tlast), .dda_fsm_out_tready(tready),
        .frame_sync_in(sync), .rd_hcount_in(rd_hc), .rd_req_in(rd_req),
        .rd_data_out(rd_data), .rd_valid_out(rd_valid),
        .frame_swapped_out(swapped), .frame_dropped_out(dropped),
        .beat_error_out(err), .cols_written_out(cols)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic logic [37:0] mk(input logic [8:0] hc, input logic [7:0] lh);
        return {hc, lh, hc[0], hc[3:0], 16'hA000 | {7'b0, hc}};
    endfunction

    // Expected stored word with a hand-computed (already clamped) lineHeight.
    function automatic logic [28:0] ew(input logic [8:0] hc, input logic [7:0] lh);
        return {lh, hc[0], hc[3:0], 16'hA000 | {7'b0, hc}};
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send_beat(input logic [8:0] hc, input logic [7:0] lh, input logic last);
        int n = 0;
        tvalid = 1'b1; tdata = mk(hc, lh); tlast = last;
        while (!tready && n < 100) begin tick(); n++; end
        if (!tready) chk("tready_timeout", 32'(tready), 32'd1);
        tick();
        tvalid = 1'b0; tlast = 1'b0;
    endtask

    task automatic pulse_sync();
        sync = 1'b1; tick(); sync = 1'b0;
    endtask

    task automatic read_col(input string tag, input logic [8:0] hc, input logic [28:0] exp);
        rd_req = 1'b1; rd_hc = hc; tick(); rd_req = 1'b0;
        chk({tag, "_valid"}, 32'(rd_valid), 32'd1);
        chk(tag, 32'(rd_data), 32'(exp));
    endtask

    initial begin
        bit bp_ok;
        #1;
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_cols", 32'(cols), 32'd0);
        chk("rst_swapped", 32'(swapped), 32'd0);
        @(negedge clk); rst = 1'b0; tick();
        chk("rst_tready", 32'(tready), 32'd1);

        // Frame 1 into bank 0, lineHeight = hcount[7:0]
        for (int i = 0; i < 320; i++) send_beat(9'(i), 8'(i), i == 319);
        chk("f1_tready_done", 32'(tready), 32'd0);
        chk("f1_cols", 32'(cols), 32'd320);
        chk("f1_err", 32'(err), 32'd0);
        pulse_sync();
        chk("f1_swapped", 32'(swapped), 32'd1);
        tick();
        chk("f1_swapped_once", 32'(swapped), 32'd0);
        chk("f1_tready_back", 32'(tready), 32'd1);
        chk("f1_cols_clr", 32'(cols), 32'd0);
        read_col("f1_col100", 9'd100, ew(9'd100, 8'd100));
        tick();
        chk("rd_valid_1cyc", 32'(rd_valid), 32'd0);
        read_col("f1_col200_clamp", 9'd200, ew(9'd200, 8'd180));
        read_col("f1_col319", 9'd319, ew(9'd319, 8'd63));
        read_col("rd_oob400", 9'd400, 29'd0);

        // Frame 2 into bank 1, lineHeight = hcount+7, column 5 oversized
        for (int i = 0; i < 320; i++)
            send_beat(9'(i), (i == 5) ? 8'd250 : 8'(i + 7), i == 319);

        // Backpressure: held beat must wait for the swap
        bp_ok = 1'b1;
        tvalid = 1'b1; tdata = mk(9'd10, 8'd33); tlast = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (tready) bp_ok = 1'b0;
            tick();
        end
        chk("bp_tready_low", 32'(bp_ok), 32'd1);
        chk("bp_cols_held", 32'(cols), 32'd320);
        sync = 1'b1; rd_req = 1'b1; rd_hc = 9'd5;
        tick();
        sync = 1'b0; rd_req = 1'b0;
        chk("bp_swapped", 32'(swapped), 32'd1);
        chk("swap_rd_old_bank", 32'(rd_data), 32'(ew(9'd5, 8'd5)));
        tick();
        tvalid = 1'b0;
        chk("bp_accept_after_swap", 32'(cols), 32'd1);
        read_col("f2_col5_clamp", 9'd5, ew(9'd5, 8'd180));
        read_col("f2_col10_untouched", 9'd10, ew(9'd10, 8'd17));

        // Frame 3 into bank 0: dropped sync at 200 columns
        for (int i = 0; i < 199; i++) send_beat(9'(i), 8'd1, 1'b0);
        pulse_sync();
        chk("drop_pulse", 32'(dropped), 32'd1);
        chk("drop_no_swap", 32'(swapped), 32'd0);
        chk("drop_cols", 32'(cols), 32'd200);
        chk("drop_tready", 32'(tready), 32'd1);
        for (int i = 199; i < 319; i++) send_beat(9'(i), 8'd2, 1'b0);
        send_beat(9'd320, 8'd9, 1'b0);
        chk("oob_err", 32'(err), 32'd1);
        chk("oob_not_counted", 32'(cols), 32'd320);
        sync = 1'b1;
        send_beat(9'd319, 8'd3, 1'b1);
        sync = 1'b0;
        chk("tlast_sync_dropped", 32'(dropped), 32'd1);
        chk("tlast_sync_noswap", 32'(swapped), 32'd0);
        chk("tlast_sync_done", 32'(tready), 32'd0);
        pulse_sync();
        chk("f3_swapped", 32'(swapped), 32'd1);
        read_col("f3_col250", 9'd250, ew(9'd250, 8'd2));
        read_col("f3_col10", 9'd10, ew(9'd10, 8'd1));
        read_col("f3_col319", 9'd319, ew(9'd319, 8'd3));

        // Mid-frame asynchronous reset
        for (int i = 0; i < 150; i++) send_beat(9'(i), 8'(i), 1'b0);
        chk("mid_cols", 32'(cols), 32'd150);
        #3 rst = 1'b1;
        #1;
        chk("arst_cols", 32'(cols), 32'd0);
        chk("arst_err", 32'(err), 32'd0);
        chk("arst_rd_data", 32'(rd_data), 32'd0);
        chk("arst_tready", 32'(tready), 32'd1);
        @(negedge clk); rst = 1'b0; tick();

        // Early tlast after 100 beats, bank 0 again
        for (int i = 0; i < 100; i++) send_beat(9'(i), 8'(i + 1), i == 99);
        chk("early_tlast_done", 32'(tready), 32'd0);
        chk("early_tlast_err", 32'(err), 32'd1);
        chk("early_tlast_cols", 32'(cols), 32'd100);
        pulse_sync();
        chk("f4_swapped", 32'(swapped), 32'd1);
        read_col("f4_col50", 9'd50, ew(9'd50, 8'd51));
`ifdef DDA_COLUMN_STORE_VALID_EN
        read_col("vmap_col150", 9'd150, 29'd0);
        read_col("vmap_col120_prerst", 9'd120, 29'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
